// File: rtl/evm_pkg.sv
// Shared types and helpers for the voting machine ballot path.
package evm_pkg;

  typedef enum logic [1:0] {
    StClosed = 2'd0,
    StIdle   = 2'd1,
    StArmed  = 2'd2,
    StHold   = 2'd3
  } ballot_state_e;

  localparam int unsigned NCandDefault = 6;

  // Candidate index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n_cand);
    return (n_cand > 1) ? $clog2(n_cand) : 1;
  endfunction

endpackage

// File: rtl/cand_priority_arb.sv
// Lowest-index-first encoder over the candidate press pulses.
module cand_priority_arb
  import evm_pkg::*;
#(
  parameter int unsigned N_CAND = NCandDefault,
  localparam int unsigned IdW   = id_width(N_CAND)
) (
  input  logic [N_CAND-1:0] cand_valid_i,
  output logic              hit_o,
  output logic [IdW-1:0]    idx_o
);

  // Scan from the top so the lowest set index is written last and wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = int'(N_CAND) - 1; i >= 0; i--) begin
      if (cand_valid_i[i]) begin
        hit_o = 1'b1;
        idx_o = IdW'(i);
      end
    end
  end

endmodule

// File: rtl/ballot_controller.sv
// Single shared ballot sequencer: CLOSED -> IDLE -> ARMED -> HOLD with vote strobe and counters.
// Optional ARMED timeout enabled by defining BALLOT_TIMEOUT_EN.
module ballot_controller
  import evm_pkg::*;
#(
  parameter int unsigned N_CAND      = NCandDefault,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned HOLD_CYC    = 10,
  localparam int unsigned IdW        = id_width(N_CAND)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              poll_open,
  input  logic              issue_ballot,
  input  logic [N_CAND-1:0] cand_valid,
  output logic              vote_strobe,
  output logic [IdW-1:0]    vote_id,
  output logic              ballot_ready,
  output logic              busy,
  output logic              result_mode,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  ballots_issued,
  output logic [CNT_W-1:0]  votes_cast,
  output logic [CNT_W-1:0]  ballots_expired
);

  localparam int unsigned HoldW = $clog2(HOLD_CYC + 1);

  if (HOLD_CYC < 1 || TIMEOUT_CYC < 2 || N_CAND < 2 || N_CAND > 16) begin : g_bad_params
    $error("ballot_controller: parameter out of range");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  ballot_state_e    state_q, state_d;
  logic             vote_strobe_q, vote_strobe_d;
  logic [IdW-1:0]   vote_id_q, vote_id_d;
  logic             ballot_ready_q, ballot_ready_d;
  logic             busy_q, busy_d;
  logic             result_mode_q, result_mode_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] cast_q, cast_d;
  logic [CNT_W-1:0] expired_q, expired_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

`ifdef BALLOT_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC);
  logic [TmrW-1:0] timer_q, timer_d;
`endif

  logic           arb_hit;
  logic [IdW-1:0] arb_idx;

  cand_priority_arb #(
    .N_CAND (N_CAND)
  ) u_arb (
    .cand_valid_i (cand_valid),
    .hit_o        (arb_hit),
    .idx_o        (arb_idx)
  );

  always_comb begin
    state_d       = state_q;
    vote_strobe_d = 1'b0;
    vote_id_d     = '0;
    issued_d      = issued_q;
    cast_d        = cast_q;
    expired_d     = expired_q;
    hold_cnt_d    = hold_cnt_q;
`ifdef BALLOT_TIMEOUT_EN
    timer_d       = timer_q;
`endif

    unique case (state_q)
      StClosed: begin
        if (poll_open) state_d = StIdle;
      end
      StIdle: begin
        if (!poll_open) begin
          state_d = StClosed;
        end else if (issue_ballot) begin
          state_d  = StArmed;
          issued_d = sat_inc(issued_q);
`ifdef BALLOT_TIMEOUT_EN
          timer_d  = '0;
`endif
        end
      end
      StArmed: begin
        // Closing the poll voids the ballot even if a press lands the same cycle.
        if (!poll_open) begin
          state_d   = StClosed;
          expired_d = sat_inc(expired_q);
        end else if (arb_hit) begin
          state_d       = StHold;
          vote_strobe_d = 1'b1;
          vote_id_d     = arb_idx;
          cast_d        = sat_inc(cast_q);
          hold_cnt_d    = '0;
        end
`ifdef BALLOT_TIMEOUT_EN
        else if (timer_q == TmrW'(TIMEOUT_CYC - 1)) begin
          state_d   = StIdle;
          expired_d = sat_inc(expired_q);
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
`endif
      end
      StHold: begin
        if (hold_cnt_q == HoldW'(HOLD_CYC - 1)) begin
          state_d = poll_open ? StIdle : StClosed;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      default: state_d = StClosed;
    endcase

    ballot_ready_d = (state_d == StArmed);
    busy_d         = (state_d == StHold);
    result_mode_d  = (state_d == StClosed);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StClosed;
      vote_strobe_q  <= 1'b0;
      vote_id_q      <= '0;
      ballot_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      result_mode_q  <= 1'b1;
      issued_q       <= '0;
      cast_q         <= '0;
      expired_q      <= '0;
      hold_cnt_q     <= '0;
`ifdef BALLOT_TIMEOUT_EN
      timer_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      vote_strobe_q  <= vote_strobe_d;
      vote_id_q      <= vote_id_d;
      ballot_ready_q <= ballot_ready_d;
      busy_q         <= busy_d;
      result_mode_q  <= result_mode_d;
      issued_q       <= issued_d;
      cast_q         <= cast_d;
      expired_q      <= expired_d;
      hold_cnt_q     <= hold_cnt_d;
`ifdef BALLOT_TIMEOUT_EN
      timer_q        <= timer_d;
`endif
    end
  end

  assign vote_strobe     = vote_strobe_q;
  assign vote_id         = vote_id_q;
  assign ballot_ready    = ballot_ready_q;
  assign busy            = busy_q;
  assign result_mode     = result_mode_q;
  assign state           = state_q;
  assign ballots_issued  = issued_q;
  assign votes_cast      = cast_q;
  assign ballots_expired = expired_q;

endmodule
